hazard_control: RTL and testbench

//   Drives the stall/flush/forward controls that steer the fetch/decode and decode/execute pipeline registers.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_control_forward_sel.sv | 25 ++
 rtl/hazard_control.sv | 122 ++++++++++++
 tb/tb_hazard_control.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: forwarding selects, FSM states, x0 index.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_control_forward_sel.sv
// Operand forwarding select for one execute-stage source register.
// Memory stage has priority over writeback; x0 never forwards.
module forward_sel
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rsE,
    input  logic [REG_ADDR_W-1:0] rdM,
    input  logic                  regWriteM,
    input  logic [REG_ADDR_W-1:0] rdW,
    input  logic                  regWriteW,
    output fwd_sel_t              sel
);

    localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(REG_ZERO);

    // Pick the youngest in-flight producer of rsE; later assignment wins.
    always_comb begin
        sel = FWD_RF;
        if (regWriteW && (rdW != ZERO) && (rdW == rsE)) sel = FWD_W;
        if (regWriteM && (rdM != ZERO) && (rdM == rsE)) sel = FWD_M;
    end

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard unit: load-use and taken-branch stall/flush, multi-cycle
// MUL/DIV hold of execute, and ALU operand forwarding selects.
module hazard_control
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MD_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1D,
    input  logic [REG_ADDR_W-1:0] rs2D,
    input  logic [REG_ADDR_W-1:0] rs1E,
    input  logic [REG_ADDR_W-1:0] rs2E,
    input  logic [REG_ADDR_W-1:0] rdE,
    input  logic                  memReadE,
    input  logic                  PCSrcE,
    input  logic                  mdStartE,
    input  logic [REG_ADDR_W-1:0] rdM,
    input  logic [REG_ADDR_W-1:0] rdW,
    input  logic                  regWriteM,
    input  logic                  regWriteW,
    output logic                  stallF,
    output logic                  stallD,
    output logic                  stallE,
    output logic                  flushD,
    output logic                  flushE,
    output fwd_sel_t              forwardAE,
    output fwd_sel_t              forwardBE,
    output logic                  mdDone
);

    localparam int CNT_W = $clog2(MD_LATENCY);
    localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(REG_ZERO);

    if (MD_LATENCY < 2) begin : g_lat_chk
        $error("hazard_control: MD_LATENCY must be >= 2");
    end

    hz_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             mdStall, mdDoneRaw, lwStall;
    fwd_sel_t         fwdA, fwdB;

    // MUL/DIV occupancy state and remaining-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: the start cycle stalls, then count down; cnt==1 is the result cycle.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        mdStall   = 1'b0;
        mdDoneRaw = 1'b0;
        case (state)
            RUN: begin
                if (mdStartE) begin
                    mdStall = 1'b1;
                    cnt_n   = CNT_W'(MD_LATENCY - 1);
                    state_n = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (cnt > CNT_W'(1)) begin
                    mdStall = 1'b1;
                    cnt_n   = cnt - CNT_W'(1);
                end else begin
                    mdDoneRaw = 1'b1;
                    state_n   = RUN;
                end
            end
            default: state_n = RUN;
        endcase
    end

    assign lwStall = memReadE && (rdE != ZERO) && ((rdE == rs1D) || (rdE == rs2D));

    forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rsE(rs1E), .rdM(rdM), .regWriteM(regWriteM),
        .rdW(rdW), .regWriteW(regWriteW), .sel(fwdA)
    );

    forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rsE(rs2E), .rdM(rdM), .regWriteM(regWriteM),
        .rdW(rdW), .regWriteW(regWriteW), .sel(fwdB)
    );

    // Output controls; while in reset, both pipe registers are held cleared.
    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        flushD    = 1'b1;
        flushE    = 1'b1;
        forwardAE = FWD_RF;
        forwardBE = FWD_RF;
        mdDone    = 1'b0;
        if (rst_n) begin
            stallF    = lwStall | mdStall;
            stallD    = lwStall | mdStall;
            stallE    = mdStall;
            flushE    = (lwStall | PCSrcE) & ~mdStall;
            flushD    = PCSrcE & ~mdStall;
            forwardAE = fwdA;
            forwardBE = fwdB;
            mdDone    = mdDoneRaw;
        end
    end

    // A branch cannot resolve in the same cycle a MUL/DIV enters execute.
    a_no_br_md : assert property (@(posedge clk) disable iff (!rst_n)
        !(state == RUN && mdStartE && PCSrcE))
        else $error("hazard_control: PCSrcE with mdStartE in RUN");

endmodule

// File: tb/tb_hazard_control.sv
// Randomized + directed bench for hazard_control against a cycle-indexed reference model.
module tb_hazard_control;
    import hazard_pkg::*;

    localparam int L = 4;

    logic       clk, rst_n;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       memReadE, PCSrcE, mdStartE, regWriteM, regWriteW;
    logic       stallF, stallD, stallE, flushD, flushE, mdDone;
    fwd_sel_t   forwardAE, forwardBE;

    int errors = 0;
    int checks = 0;

    // Reference model: an MD op is identified by the cycle it started.
    bit md_active;
    int md_start;
    int cyc;

    hazard_control #(.REG_ADDR_W(5), .MD_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .memReadE(memReadE), .PCSrcE(PCSrcE), .mdStartE(mdStartE),
        .rdM(rdM), .rdW(rdW), .regWriteM(regWriteM), .regWriteW(regWriteW),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .mdDone(mdDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got=running exp=done");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int fwd_ref(input logic [4:0] rs, input logic [4:0] m, input logic wm,
                                   input logic [4:0] w, input logic ww);
        if (wm && m != 0 && m == rs) return 2;
        if (ww && w != 0 && w == rs) return 1;
        return 0;
    endfunction

    // Compare every output against the model for the current inputs.
    task automatic check_all(input string tag);
        bit mds, done, lw;
        int off;
        #1;
        mds = 0; done = 0;
        if (rst_n) begin
            if (!md_active) mds = mdStartE;
            else begin
                off  = cyc - md_start;
                mds  = (off < L - 1);
                done = (off == L - 1);
            end
        end
        lw = memReadE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
        if (!rst_n) begin
            chk({tag, ".stallF"}, stallF, 0);
            chk({tag, ".stallD"}, stallD, 0);
            chk({tag, ".stallE"}, stallE, 0);
            chk({tag, ".flushD"}, flushD, 1);
            chk({tag, ".flushE"}, flushE, 1);
            chk({tag, ".fwdA"}, forwardAE, 0);
            chk({tag, ".fwdB"}, forwardBE, 0);
            chk({tag, ".mdDone"}, mdDone, 0);
        end else begin
            chk({tag, ".stallF"}, stallF, lw | mds);
            chk({tag, ".stallD"}, stallD, lw | mds);
            chk({tag, ".stallE"}, stallE, mds);
            chk({tag, ".flushD"}, flushD, PCSrcE & ~mds);
            chk({tag, ".flushE"}, flushE, (lw | PCSrcE) & ~mds);
            chk({tag, ".fwdA"}, forwardAE, fwd_ref(rs1E, rdM, regWriteM, rdW, regWriteW));
            chk({tag, ".fwdB"}, forwardBE, fwd_ref(rs2E, rdM, regWriteM, rdW, regWriteW));
            chk({tag, ".mdDone"}, mdDone, done);
        end
    endtask

    // Check, then advance one clock with the model following the same inputs.
    task automatic tick(input string tag);
        bit start_op, end_op;
        check_all(tag);
        start_op = rst_n && !md_active && mdStartE;
        end_op   = rst_n && md_active && (cyc - md_start == L - 1);
        @(posedge clk);
        if (start_op) begin md_active = 1; md_start = cyc; end
        else if (end_op) md_active = 0;
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        memReadE = 0; PCSrcE = 0; mdStartE = 0; regWriteM = 0; regWriteW = 0;
    endtask

    int dones;

    initial begin
        md_active = 0; md_start = 0; cyc = 0;
        rst_n = 0;
        idle_inputs();
        check_all("reset");
        @(posedge clk); cyc++; #1;
        rst_n = 1;
        tick("idle");

        // Load-use on rs2D, then x0 destination must not stall.
        memReadE = 1; rdE = 5; rs2D = 5;
        #1 chk("lw.stallF", stallF, 1); chk("lw.flushE", flushE, 1);
        tick("lw");
        rdE = 0; rs1D = 0; rs2D = 0;
        #1 chk("lw_x0.stallF", stallF, 0);
        tick("lw_x0");
        idle_inputs();

        // Taken branch, alone and together with load-use.
        PCSrcE = 1;
        #1 chk("br.flushD", flushD, 1); chk("br.stallF", stallF, 0);
        tick("br");
        memReadE = 1; rdE = 3; rs1D = 3;
        #1 chk("br_lw.flushE", flushE, 1); chk("br_lw.stallD", stallD, 1);
        chk("br_lw.flushD", flushD, 1);
        tick("br_lw");
        idle_inputs();

        // MD op with load-use during busy: flushE must stay low.
        mdStartE = 1;
        tick("md0");
        memReadE = 1; rdE = 9; rs1D = 9;
        #1 chk("md1.flushE", flushE, 0); chk("md1.stallE", stallE, 1);
        tick("md1");
        tick("md2");
        idle_inputs();
        #1 chk("md3.mdDone", mdDone, 1); chk("md3.stallE", stallE, 0);
        tick("md3");
        tick("md4");

        // Forwarding priority and x0.
        rdM = 7; rdW = 7; regWriteM = 1; regWriteW = 1; rs1E = 7;
        #1 chk("fwd.M", forwardAE, FWD_M);
        tick("fwdM");
        regWriteM = 0;
        #1 chk("fwd.W", forwardAE, FWD_W);
        tick("fwdW");
        regWriteM = 1; rdM = 0; rdW = 0; rs1E = 0;
        #1 chk("fwd.x0", forwardAE, FWD_RF);
        tick("fwdx0");
        idle_inputs();

        // Back-to-back MD ops: held op then a fresh one at t+L.
        dones = 0;
        mdStartE = 1;
        for (int i = 0; i < 2 * L; i++) begin
            #1 if (mdDone === 1'b1) dones++;
            tick("b2b");
        end
        mdStartE = 0;
        chk("b2b.dones", dones, 2);

        // Asynchronous reset mid-busy (cnt==2), then no stray mdDone.
        mdStartE = 1;
        tick("rst_md0");
        tick("rst_md1");
        mdStartE = 0;
        #2 rst_n = 0;
        md_active = 0;
        #1 chk("rst_mid.stallE", stallE, 0); chk("rst_mid.flushD", flushD, 1);
        check_all("rst_mid");
        @(posedge clk); cyc++; #1;
        rst_n = 1;
        for (int i = 0; i < L; i++) tick("post_rst");

        // Randomized traffic; never a branch alongside a new MD op in RUN.
        for (int i = 0; i < 600; i++) begin
            rs1D = 5'($urandom_range(0, 7)); rs2D = 5'($urandom_range(0, 7));
            rs1E = 5'($urandom_range(0, 7)); rs2E = 5'($urandom_range(0, 7));
            rdE  = 5'($urandom_range(0, 7)); rdM  = 5'($urandom_range(0, 7));
            rdW  = 5'($urandom_range(0, 7));
            memReadE  = ($urandom_range(0, 2) == 0);
            regWriteM = $urandom_range(0, 1) == 1;
            regWriteW = $urandom_range(0, 1) == 1;
            PCSrcE    = ($urandom_range(0, 5) == 0);
            if (md_active) mdStartE = ($urandom_range(0, 3) != 0);
            else           mdStartE = ($urandom_range(0, 7) == 0);
            if (!md_active && mdStartE) PCSrcE = 0;
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
